mimo_row_loader: RTL and testbench

- Upstream feeder for the row normalization stage of the 4x4 MIMO detector.
- Accepts a serial stream of complex samples: per row, N channel entries h[0..N-1] followed by one received sample y.
- Assembles each row into the packed H/y format consumed by the normalization stage.
- Double-buffered, so a new row loads while the previous one waits for the consumer.

---
 rtl/mimo_row_loader.sv | 119 +++++++++++
 tb/tb_mimo_row_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mimo_row_loader.sv
// Double-buffered row assembler: collects N channel words plus one received sample
// per row from a serial complex stream and presents them packed for the row normalizer.
module mimo_row_loader #(
  parameter int unsigned WL = 16,
  parameter int unsigned N  = 4,
  parameter int unsigned M  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WL-1:0]                       in_x,
  input  logic [WL-1:0]                       in_y,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WL*N-1:0]                     Hout_x,
  output logic [WL*N-1:0]                     Hout_y,
  output logic [WL-1:0]                       yout_x,
  output logic [WL-1:0]                       yout_y,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] row_idx,
  output logic                                row_last
);

  localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned CW = $clog2(N + 1);

  logic [WL*N-1:0] hx_q [2];
  logic [WL*N-1:0] hy_q [2];
  logic [WL-1:0]   yx_q [2];
  logic [WL-1:0]   yy_q [2];
  logic [IW-1:0]   tag_q [2];
  logic [1:0]      full_q;
  logic            wptr_q;
  logic            rptr_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   lrow_q;
  logic            armed_q;

  logic accept;
  logic drain;

  // Handshake decode uses registered state only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = armed_q && !full_q[wptr_q];
    out_valid = full_q[rptr_q];
    accept    = in_valid && in_ready;
    drain     = out_valid && out_ready;
  end

  always_comb begin
    Hout_x   = hx_q[rptr_q];
    Hout_y   = hy_q[rptr_q];
    yout_x   = yx_q[rptr_q];
    yout_y   = yy_q[rptr_q];
    row_idx  = tag_q[rptr_q];
    row_last = (tag_q[rptr_q] == IW'(M - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        hx_q[b]  <= '0;
        hy_q[b]  <= '0;
        yx_q[b]  <= '0;
        yy_q[b]  <= '0;
        tag_q[b] <= '0;
      end
      full_q  <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      cnt_q   <= '0;
      lrow_q  <= '0;
      armed_q <= 1'b0;
    end else if (flush) begin
      for (int b = 0; b < 2; b++) begin
        hx_q[b]  <= '0;
        hy_q[b]  <= '0;
        yx_q[b]  <= '0;
        yy_q[b]  <= '0;
        tag_q[b] <= '0;
      end
      full_q  <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      cnt_q   <= '0;
      lrow_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        if (cnt_q == CW'(N)) begin
          // Row complete: y word, tag, hand the buffer to the read side.
          yx_q[wptr_q]   <= in_x;
          yy_q[wptr_q]   <= in_y;
          tag_q[wptr_q]  <= lrow_q;
          full_q[wptr_q] <= 1'b1;
          wptr_q         <= ~wptr_q;
          cnt_q          <= '0;
          lrow_q         <= (lrow_q == IW'(M - 1)) ? '0 : lrow_q + IW'(1);
        end else begin
          for (int i = 0; i < int'(N); i++) begin
            if (cnt_q == CW'(i)) begin
              hx_q[wptr_q][i*WL +: WL] <= in_x;
              hy_q[wptr_q][i*WL +: WL] <= in_y;
            end
          end
          cnt_q <= cnt_q + CW'(1);
        end
      end
      // Drain always targets the other buffer when it coincides with a fill.
      if (drain) begin
        full_q[rptr_q] <= 1'b0;
        rptr_q         <= ~rptr_q;
      end
    end
  end

endmodule

// File: tb/tb_mimo_row_loader.sv
// Randomized bench for mimo_row_loader with a queue-of-rows reference model.
module tb_mimo_row_loader;

  localparam int WL = 16;
  localparam int N  = 4;
  localparam int M  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WL-1:0] in_x = '0;
  logic [WL-1:0] in_y = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WL*N-1:0] Hout_x, Hout_y;
  logic [WL-1:0] yout_x, yout_y;
  logic [1:0]    row_idx;
  logic          row_last;

  mimo_row_loader #(.WL(WL), .N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .Hout_x(Hout_x), .Hout_y(Hout_y), .yout_x(yout_x), .yout_y(yout_y),
    .row_idx(row_idx), .row_last(row_last)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: rows in flight are a queue; the loader may hold at most two.
  typedef struct {
    logic [63:0] hx;
    logic [63:0] hy;
    logic [15:0] yx;
    logic [15:0] yy;
    int          idx;
  } row_t;

  row_t q[$];
  row_t cur;
  int   cnt = 0;
  int   lrow = 0;
  bit   just_cleared = 1'b1;

  task automatic model_clear();
    q.delete();
    cnt  = 0;
    lrow = 0;
    cur.hx = '0; cur.hy = '0; cur.yx = '0; cur.yy = '0; cur.idx = 0;
    just_cleared = 1'b1;
  endtask

  // 0: always ready, 1: never ready, 2: random
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd0);
      check("rst_hx", Hout_x, 64'd0);
      model_clear();
    end else begin
      check("in_ready", 64'(in_ready), 64'((!just_cleared) && (q.size() < 2)));
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (out_valid && q.size() > 0) begin
        check("hx", Hout_x, q[0].hx);
        check("hy", Hout_y, q[0].hy);
        check("yx", 64'(yout_x), 64'(q[0].yx));
        check("yy", 64'(yout_y), 64'(q[0].yy));
        check("row_idx", 64'(row_idx), 64'(q[0].idx));
        check("row_last", 64'(row_last), 64'(q[0].idx == M - 1));
      end
      just_cleared = 1'b0;
      if (flush) begin
        model_clear();
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) begin
          if (cnt < N) begin
            cur.hx[cnt*16 +: 16] = in_x;
            cur.hy[cnt*16 +: 16] = in_y;
            cnt++;
          end else begin
            cur.yx  = in_x;
            cur.yy  = in_y;
            cur.idx = lrow;
            q.push_back(cur);
            lrow = (lrow + 1) % M;
            cnt  = 0;
          end
        end
      end
    end
  end

  // Drivers are entered and left at posedge+1.
  task automatic send_sample(input logic [15:0] x, input logic [15:0] y, input int gap);
    bit ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_x = x; in_y = y;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("stall_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_row(input logic [63:0] hx, input logic [63:0] hy,
                          input logic [15:0] yx, input logic [15:0] yy, input int maxgap);
    logic [63:0] tx = hx;
    logic [63:0] ty = hy;
    for (int i = 0; i < N; i++)
      send_sample(tx[i*16 +: 16], ty[i*16 +: 16], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    send_sample(yx, yy, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic send_rand_row(input int maxgap);
    send_row({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 16'($urandom), maxgap);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed first row with known constants and one-cycle latency.
    send_row(64'h0004_0003_0002_0001, 64'hfffc_fffd_fffe_ffff, 16'd100, 16'hff9c, 0);
    @(negedge clk);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_hx", Hout_x, 64'h0004_0003_0002_0001);
    check("t1_hy", Hout_y, 64'hfffc_fffd_fffe_ffff);
    check("t1_yx", 64'(yout_x), 64'h0064);
    check("t1_yy", 64'(yout_y), 64'hff9c);
    check("t1_idx", 64'(row_idx), 64'd0);
    @(posedge clk); #1;

    // Continuous stream wraps the row index.
    repeat (5) send_rand_row(0);

    // Back-pressure: third row stalls until the consumer wakes up.
    rdy_mode = 1;
    repeat (4) @(posedge clk); #1;
    fork
      repeat (3) send_rand_row(0);
      begin repeat (40) @(posedge clk); #1 rdy_mode = 0; end
    join
    repeat (4) @(posedge clk); #1;

    // Flush discards a partial row.
    send_sample(16'h1111, 16'h2222, 0);
    send_sample(16'h3333, 16'h4444, 0);
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    send_row(64'h7fff_8000_7fff_8000, 64'h8000_7fff_8000_7fff, 16'h8000, 16'h8000, 0);
    @(negedge clk);
    check("flush_hx", Hout_x, 64'h7fff_8000_7fff_8000);
    check("flush_idx", 64'(row_idx), 64'd0);
    @(posedge clk); #1;

    // Async reset mid-row while a row is presented.
    rdy_mode = 1;
    send_rand_row(0);
    send_sample(16'h0abc, 16'h0def, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_hx", Hout_x, 64'd0);
    check("arst_yy", 64'(yout_y), 64'd0);
    check("arst_idx", 64'(row_idx), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    rdy_mode = 0;
    send_rand_row(0);

    // Extreme values with gaps, then random traffic.
    send_row(64'h8000_7fff_8000_7fff, 64'h7fff_8000_7fff_8000, 16'h8000, 16'h8000, 3);
    rdy_mode = 2;
    repeat (30) send_rand_row(3);
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drained", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
